rf_wport_arbiter: RTL and testbench
===================================

Name: rf_wport_arbiter

Overview:
- Shares the register file's single write port between two sources: the pipeline WB stage and a multi-cycle execution unit (mult/div, late load return).
- WB always has priority. Multi-cycle results are held in a DEPTH-entry FIFO and written into free WB slots.
- A per-register pending scoreboard tells the hazard unit which registers are still awaiting a multi-cycle result.
- A starvation counter requests a pipeline bubble when the FIFO cannot drain.

Parameters:
- DEPTH, 4, result FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 8, consecutive blocked cycles with FIFO non-empty before stall_req asserts.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_we  in  1  WB stage write request.
- wb_addr  in  5  WB destination register.
- wb_data  in  32  WB write data.
- mc_valid  in  1  multi-cycle result valid.
- mc_addr  in  5  multi-cycle destination register.
- mc_data  in  32  multi-cycle result data.
- mc_ready  out  1  FIFO can accept a result (count < DEPTH).
- issue_valid  in  1  multi-cycle op issued this cycle.
- issue_addr  in  5  destination of the issued op.
- rd_addr1  in  5  ID-stage read address 1.
- rd_addr2  in  5  ID-stage read address 2.
- pend1  out  1  rd_addr1 awaits a multi-cycle result.
- pend2  out  1  rd_addr2 awaits a multi-cycle result.
- RegWrite  out  1  register file write enable.
- RF_WriteAddr  out  5  register file write address.
- RF_WriteData  out  32  register file write data.
- stall_req  out  1  registered; asks the pipeline to insert a WB bubble.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset low, async):
  - FIFO empty, fifo_count=0.
  - pending[31:1]=0, starve counter=0, stall_req=0, state=IDLE.
  - While reset is low, RegWrite is forced to 0, RF_WriteAddr=0, RF_WriteData=0.
  - mc_ready=0 while reset is low.
- Write port, combinational, same cycle (the register file's write-through bypass depends on this):
  - wb_act = wb_we && wb_addr!=0.
  - If wb_act: drive the WB fields, RegWrite=1.
  - Else if FIFO non-empty: drive the FIFO head, RegWrite=1, pop at the clock edge.
  - Else RegWrite=0, addr/data=0.
- A WB write to $0 counts as a free slot.
- FIFO push: on mc_valid && mc_ready && mc_addr!=0. With mc_addr==0 the result is accepted (handshake completes) and discarded.
- mc_ready = (count<DEPTH). There is no pass-through when full: a pop in the same cycle does not enable a push.
- Push into an empty FIFO: that entry is not visible until the next cycle (no bypass).
- Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- Scoreboard:
  - issue_valid && issue_addr!=0 sets pending[issue_addr] at the edge.
  - A FIFO drain clears pending[head addr].
  - If set and clear hit the same register in the same cycle, set wins.
  - WB writes never touch pending.
  - pend1 = rd_addr1!=0 && pending[rd_addr1]; likewise pend2. Both are combinational from registered bits.
- FSM:
  - IDLE (FIFO empty) -> DRAIN on first push.
  - DRAIN -> IDLE when count reaches 0.
  - DRAIN -> STARVED when the starve counter reaches STARVE_LIMIT.
  - STARVED -> DRAIN on the edge after the first pop; stall_req deasserts at that same edge.
  - stall_req=1 exactly in STARVED.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and wb_act=1.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- The pipeline guarantees wb_we=0 on the cycle after seeing stall_req. If it does not, the arbiter keeps WB priority and remains STARVED; there is no error state.
- Reset mid-operation: all queued results and pending bits are lost. The issuing unit is reset by the same signal.

Test Plan:
- Idle WB: wb_we=1, wb_addr=5, wb_data=0x1234 with FIFO empty -> same cycle RegWrite=1, RF_WriteAddr=5, RF_WriteData=0x1234; fifo_count stays 0.
- Drain into free slot: issue_addr=8; next cycle pend1=1 with rd_addr1=8. Then mc push (8, 0xAA) with wb_we=0 -> one cycle later RegWrite=1, addr 8, data 0xAA. pending[8] clears the following edge, and pend1 drops.
- Full FIFO, DEPTH=4: four pushes while wb_we=1 continuously -> mc_ready=0 and fifo_count=4. A fifth mc_valid is held, not lost. Dropping wb_we drains entries in push order, one per cycle.
- Starvation: one entry queued, wb_we=1 for 8 cycles -> stall_req=1 on the 9th cycle. With wb_we=0 the entry drains, and stall_req=0 at the next edge.
- Same-cycle set and clear: drain of reg 3 and issue_addr=3 in the same cycle -> pending[3] remains 1. Also, mc_addr=0 push -> accepted, fifo_count unchanged.
- Async reset while fifo_count=3 and stall_req=1 -> reset low immediately gives fifo_count=0, stall_req=0, RegWrite=0, pend1=pend2=0.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter. WB has priority; multi-cycle results queue in a
// small FIFO, fill free WB slots, and are tracked by a per-register pending scoreboard.
module rf_wport_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_we,
    input  logic [4:0]               wb_addr,
    input  logic [31:0]              wb_data,
    input  logic                     mc_valid,
    input  logic [4:0]               mc_addr,
    input  logic [31:0]              mc_data,
    output logic                     mc_ready,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_addr,
    input  logic [4:0]               rd_addr1,
    input  logic [4:0]               rd_addr2,
    output logic                     pend1,
    output logic                     pend2,
    output logic                     RegWrite,
    output logic [4:0]               RF_WriteAddr,
    output logic [31:0]              RF_WriteData,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DRAIN   = 2'd1;
    localparam logic [1:0] STARVED = 2'd2;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } rfEntry_t;

    rfEntry_t      mem [DEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic [CW-1:0] count;
    logic [CW-1:0] countNext;
    logic [31:0]   pending;
    logic [31:0]   pendingNext;
    logic [SW-1:0] starveCnt;
    logic [SW-1:0] starveNext;
    logic [1:0]    state;
    logic [1:0]    stateNext;
    logic          wbAct;
    logic          notEmpty;
    logic          pop;
    logic          push;
    rfEntry_t      head;

    assign wbAct    = wb_we && (wb_addr != 5'd0);
    assign notEmpty = (count != '0);
    assign head     = mem[rdPtr];
    assign mc_ready = reset && (count < CW'(DEPTH));
    assign pop      = reset && !wbAct && notEmpty;
    // Handshake completes for $0 results, but nothing is stored
    assign push     = mc_valid && mc_ready && (mc_addr != 5'd0);

    assign fifo_count = count;
    assign pend1      = (rd_addr1 != 5'd0) && pending[rd_addr1];
    assign pend2      = (rd_addr2 != 5'd0) && pending[rd_addr2];

    // Same-cycle write port; the register file bypass relies on this timing
    always_comb begin
        RegWrite     = 1'b0;
        RF_WriteAddr = 5'd0;
        RF_WriteData = 32'd0;
        if (reset) begin
            if (wbAct) begin
                RegWrite     = 1'b1;
                RF_WriteAddr = wb_addr;
                RF_WriteData = wb_data;
            end else if (notEmpty) begin
                RegWrite     = 1'b1;
                RF_WriteAddr = head.addr;
                RF_WriteData = head.data;
            end
        end
    end

    // Occupancy, starvation count, scoreboard and FSM next state
    always_comb begin
        countNext = count;
        if (push && !pop) begin
            countNext = count + CW'(1);
        end else if (pop && !push) begin
            countNext = count - CW'(1);
        end

        starveNext = starveCnt;
        if (pop || !notEmpty) begin
            starveNext = '0;
        end else if (wbAct && (starveCnt != SW'(STARVE_LIMIT))) begin
            starveNext = starveCnt + SW'(1);
        end

        pendingNext = pending;
        if (pop) begin
            pendingNext[head.addr] = 1'b0;
        end
        if (issue_valid && (issue_addr != 5'd0)) begin
            pendingNext[issue_addr] = 1'b1;
        end
        pendingNext[0] = 1'b0;

        stateNext = state;
        case (state)
            IDLE: begin
                if (push) stateNext = DRAIN;
            end
            DRAIN: begin
                if (countNext == '0) begin
                    stateNext = IDLE;
                end else if (starveNext == SW'(STARVE_LIMIT)) begin
                    stateNext = STARVED;
                end
            end
            STARVED: begin
                if (pop) stateNext = (countNext == '0) ? IDLE : DRAIN;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            stall_req <= 1'b0;
            count     <= '0;
            rdPtr     <= '0;
            wrPtr     <= '0;
            starveCnt <= '0;
            pending   <= '0;
        end else begin
            state     <= stateNext;
            stall_req <= (stateNext == STARVED);
            count     <= countNext;
            starveCnt <= starveNext;
            pending   <= pendingNext;
            if (pop)  rdPtr <= rdPtr + AW'(1);
            if (push) wrPtr <= wrPtr + AW'(1);
        end
    end

    // Storage needs no reset; occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= '{addr: mc_addr, data: mc_data};
    end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_rf_wport_arbiter;
    localparam int unsigned DEPTH        = 4;
    localparam int unsigned STARVE_LIMIT = 8;
    localparam int unsigned CW           = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wb_we = 1'b0, mc_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]    wb_addr = '0, mc_addr = '0, issue_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
    logic [31:0]   wb_data = '0, mc_data = '0;
    logic          mc_ready, pend1, pend2, RegWrite, stall_req;
    logic [4:0]    RF_WriteAddr;
    logic [31:0]   RF_WriteData;
    logic [CW-1:0] fifo_count;

    int vectors = 0;
    int errors  = 0;

    typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t q[$];
    bit   pend[32];
    int   starve;
    bit   stalled;

    rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data), .mc_ready(mc_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .pend1(pend1), .pend2(pend2),
        .RegWrite(RegWrite), .RF_WriteAddr(RF_WriteAddr), .RF_WriteData(RF_WriteData),
        .stall_req(stall_req), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        q.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        starve  = 0;
        stalled = 1'b0;
    endtask

    task automatic idle_inputs();
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        mc_valid = 1'b0; mc_addr = '0; mc_data = '0;
        issue_valid = 1'b0; issue_addr = '0;
    endtask

    // One clock: the reference model advances on the edge using the applied inputs
    task automatic cycle();
        int sz;
        bit wa, pop, acc;
        logic [4:0] ha;
        @(posedge clk);
        sz  = q.size();
        wa  = wb_we && (wb_addr != 5'd0);
        pop = !wa && (sz > 0);
        acc = mc_valid && (sz < DEPTH);
        ha  = (sz > 0) ? q[0].a : 5'd0;
        if (!reset) begin
            model_clear();
        end else begin
            if (pop) q.delete(0);
            if (acc && (mc_addr != 5'd0)) q.push_back({mc_addr, mc_data});
            if (pop) pend[ha] = 1'b0;
            if (issue_valid && (issue_addr != 5'd0)) pend[issue_addr] = 1'b1;
            if (pop || (sz == 0)) starve = 0;
            else if (wa && (starve < STARVE_LIMIT)) starve++;
            if (stalled) begin
                if (pop) stalled = 1'b0;
            end else if (starve == STARVE_LIMIT) begin
                stalled = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD; mc_valid = 1'b1; mc_addr = 5'd6;
        rd_addr1 = 5'd5; rd_addr2 = 5'd6;
        @(posedge clk); #2;
        vectors++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %0b exp 0", RegWrite); end
        vectors++; if (RF_WriteAddr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", RF_WriteAddr); end
        vectors++; if (RF_WriteData !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", RF_WriteData); end
        vectors++; if (mc_ready !== 1'b0) begin errors++; $display("FAIL reset_mc_ready got %0b exp 0", mc_ready); end
        vectors++; if (fifo_count !== CW'(0)) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        vectors++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall_req); end
        vectors++; if ({pend1, pend2} !== 2'b00) begin errors++; $display("FAIL reset_pend got %b exp 00", {pend1, pend2}); end
        @(posedge clk); #1;
        reset = 1'b1;
        idle_inputs();
        rd_addr1 = '0; rd_addr2 = '0;
        model_clear();
        #1;
        vectors++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL post_reset_mc_ready got %0b exp 1", mc_ready); end
    endtask

    task automatic test_idle_wb();
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        #1;
        vectors++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL idle_wb_we got %0b exp 1", RegWrite); end
        vectors++; if (RF_WriteAddr !== 5'd5) begin errors++; $display("FAIL idle_wb_addr got %0d exp 5", RF_WriteAddr); end
        vectors++; if (RF_WriteData !== 32'h1234) begin errors++; $display("FAIL idle_wb_data got %h exp 1234", RF_WriteData); end
        cycle();
        vectors++; if (fifo_count !== CW'(0)) begin errors++; $display("FAIL idle_wb_count got %0d exp 0", fifo_count); end
        wb_addr = 5'd0;
        #1;
        vectors++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL wb_to_r0 got %0b exp 0", RegWrite); end
        idle_inputs();
    endtask

    task automatic test_drain();
        issue_valid = 1'b1; issue_addr = 5'd8; rd_addr1 = 5'd8;
        #1;
        vectors++; if (pend1 !== 1'b0) begin errors++; $display("FAIL drain_pend_early got %0b exp 0", pend1); end
        cycle();
        issue_valid = 1'b0;
        mc_valid = 1'b1; mc_addr = 5'd8; mc_data = 32'hAA;
        #1;
        vectors++; if (pend1 !== 1'b1) begin errors++; $display("FAIL drain_pend_set got %0b exp 1", pend1); end
        vectors++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL drain_no_bypass got %0b exp 0", RegWrite); end
        cycle();
        mc_valid = 1'b0;
        #1;
        vectors++; if ({RegWrite, RF_WriteAddr, RF_WriteData} !== {1'b1, 5'd8, 32'hAA})
            begin errors++; $display("FAIL drain_write got we=%0b a=%0d d=%h exp we=1 a=8 d=aa", RegWrite, RF_WriteAddr, RF_WriteData); end
        vectors++; if (pend1 !== 1'b1) begin errors++; $display("FAIL drain_pend_hold got %0b exp 1", pend1); end
        cycle();
        vectors++; if (pend1 !== 1'b0) begin errors++; $display("FAIL drain_pend_clear got %0b exp 0", pend1); end
        vectors++; if (fifo_count !== CW'(0)) begin errors++; $display("FAIL drain_count got %0d exp 0", fifo_count); end
        rd_addr1 = '0;
    endtask

    task automatic test_full();
        logic [4:0] order [3];
        order[0] = 5'd12; order[1] = 5'd13; order[2] = 5'd20;
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
        for (int i = 0; i < 4; i++) begin
            mc_valid = 1'b1; mc_addr = 5'(10 + i); mc_data = 32'(32'h100 + i);
            #1;
            vectors++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d got %0b exp 1", i, mc_ready); end
            cycle();
        end
        mc_addr = 5'd20; mc_data = 32'h200;
        #1;
        vectors++; if (mc_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", mc_ready); end
        vectors++; if (fifo_count !== CW'(4)) begin errors++; $display("FAIL full_count got %0d exp 4", fifo_count); end
        vectors++; if (RF_WriteAddr !== 5'd7) begin errors++; $display("FAIL full_wb_prio got %0d exp 7", RF_WriteAddr); end
        cycle();
        wb_we = 1'b0;
        #1;
        vectors++; if (fifo_count !== CW'(4)) begin errors++; $display("FAIL full_held got %0d exp 4", fifo_count); end
        vectors++; if ({mc_ready, RF_WriteAddr} !== {1'b0, 5'd10}) begin errors++; $display("FAIL full_no_passthru got rdy=%0b a=%0d exp rdy=0 a=10", mc_ready, RF_WriteAddr); end
        cycle();
        #1;
        vectors++; if ({mc_ready, RF_WriteAddr, RF_WriteData} !== {1'b1, 5'd11, 32'h101})
            begin errors++; $display("FAIL full_pop2 got rdy=%0b a=%0d d=%h exp rdy=1 a=11 d=101", mc_ready, RF_WriteAddr, RF_WriteData); end
        cycle();
        mc_valid = 1'b0;
        #1;
        vectors++; if (fifo_count !== CW'(3)) begin errors++; $display("FAIL full_pushpop_count got %0d exp 3", fifo_count); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if ({RegWrite, RF_WriteAddr} !== {1'b1, order[i]}) begin errors++; $display("FAIL full_order_%0d got we=%0b a=%0d exp a=%0d", i, RegWrite, RF_WriteAddr, order[i]); end
            cycle();
        end
        vectors++; if ({fifo_count, stall_req} !== {CW'(0), 1'b0}) begin errors++; $display("FAIL full_end got cnt=%0d stall=%0b exp 0 0", fifo_count, stall_req); end
        idle_inputs();
    endtask

    task automatic test_starve();
        wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
        mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h99;
        cycle();
        mc_valid = 1'b0;
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            #1;
            vectors++; if (stall_req !== 1'b0) begin errors++; $display("FAIL starve_early_%0d got %0b exp 0", i, stall_req); end
            cycle();
        end
        vectors++; if (stall_req !== 1'b1) begin errors++; $display("FAIL starve_assert got %0b exp 1", stall_req); end
        vectors++; if (RF_WriteAddr !== 5'd4) begin errors++; $display("FAIL starve_wb_prio got %0d exp 4", RF_WriteAddr); end
        cycle();
        vectors++; if (stall_req !== 1'b1) begin errors++; $display("FAIL starve_hold got %0b exp 1", stall_req); end
        wb_we = 1'b0;
        #1;
        vectors++; if ({RF_WriteAddr, RF_WriteData} !== {5'd9, 32'h99}) begin errors++; $display("FAIL starve_drain got a=%0d d=%h exp a=9 d=99", RF_WriteAddr, RF_WriteData); end
        cycle();
        vectors++; if ({stall_req, fifo_count} !== {1'b0, CW'(0)}) begin errors++; $display("FAIL starve_release got stall=%0b cnt=%0d exp 0 0", stall_req, fifo_count); end
        idle_inputs();
    endtask

    task automatic test_set_clear();
        issue_valid = 1'b1; issue_addr = 5'd3;
        mc_valid = 1'b1; mc_addr = 5'd3; mc_data = 32'h33;
        cycle();
        mc_addr = 5'd0; mc_data = 32'hBAD;
        rd_addr1 = 5'd3; rd_addr2 = 5'd0;
        #1;
        vectors++; if ({RF_WriteAddr, mc_ready} !== {5'd3, 1'b1}) begin errors++; $display("FAIL setclr_head got a=%0d rdy=%0b exp a=3 rdy=1", RF_WriteAddr, mc_ready); end
        cycle();
        idle_inputs();
        #1;
        vectors++; if (pend1 !== 1'b1) begin errors++; $display("FAIL setclr_set_wins got %0b exp 1", pend1); end
        vectors++; if (pend2 !== 1'b0) begin errors++; $display("FAIL setclr_r0 got %0b exp 0", pend2); end
        vectors++; if (fifo_count !== CW'(0)) begin errors++; $display("FAIL setclr_r0_discard got %0d exp 0", fifo_count); end
        rd_addr1 = '0;
    endtask

    task automatic test_random();
        int thr;
        bit ewa;
        int sz;
        logic [4:0]  ea;
        logic [31:0] ed;
        for (int n = 0; n < 480; n++) begin
            if ((n % 40) == 0) thr = $urandom_range(2, 9);
            wb_we       = ($urandom_range(0, 9) < thr);
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            mc_valid    = ($urandom_range(0, 2) != 0);
            mc_addr     = 5'($urandom_range(0, 7));
            mc_data     = $urandom;
            issue_valid = ($urandom_range(0, 1) != 0);
            issue_addr  = 5'($urandom_range(0, 7));
            rd_addr1    = 5'($urandom_range(0, 7));
            rd_addr2    = 5'($urandom_range(0, 7));
            #1;
            sz  = q.size();
            ewa = wb_we && (wb_addr != 5'd0);
            ea  = ewa ? wb_addr : ((sz > 0) ? q[0].a : 5'd0);
            ed  = ewa ? wb_data : ((sz > 0) ? q[0].d : 32'd0);
            vectors++;
            if ({RegWrite, RF_WriteAddr, RF_WriteData} !== {(ewa || sz > 0), ea, ed}) begin
                errors++; $display("FAIL rnd_wport n=%0d got we=%0b a=%0d d=%h exp we=%0b a=%0d d=%h",
                                   n, RegWrite, RF_WriteAddr, RF_WriteData, (ewa || sz > 0), ea, ed);
            end
            vectors++;
            if ({mc_ready, fifo_count, stall_req} !== {(sz < DEPTH), CW'(sz), stalled}) begin
                errors++; $display("FAIL rnd_state n=%0d got rdy=%0b cnt=%0d stall=%0b exp rdy=%0b cnt=%0d stall=%0b",
                                   n, mc_ready, fifo_count, stall_req, (sz < DEPTH), sz, stalled);
            end
            vectors++;
            if ({pend1, pend2} !== {(rd_addr1 != 0) && pend[rd_addr1], (rd_addr2 != 0) && pend[rd_addr2]}) begin
                errors++; $display("FAIL rnd_pend n=%0d got %b exp %b", n, {pend1, pend2},
                                   {(rd_addr1 != 0) && pend[rd_addr1], (rd_addr2 != 0) && pend[rd_addr2]});
            end
            cycle();
        end
        idle_inputs();
        rd_addr1 = '0; rd_addr2 = '0;
        for (int n = 0; n < 2 * DEPTH && q.size() > 0; n++) cycle();
    endtask

    task automatic test_async_reset();
        bit seen;
        wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h4;
        issue_valid = 1'b1; issue_addr = 5'd5;
        cycle();
        issue_addr = 5'd6;
        cycle();
        issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mc_valid = 1'b1; mc_addr = 5'(21 + i); mc_data = 32'(i);
            cycle();
        end
        mc_valid = 1'b0;
        rd_addr1 = 5'd5; rd_addr2 = 5'd6;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (stall_req === 1'b1) seen = 1'b1;
            else cycle();
        end
        vectors++; if (!seen) begin errors++; $display("FAIL arst_no_stall got stall=%0b exp 1 within 20 cycles", stall_req); end
        vectors++; if ({fifo_count, pend1, pend2} !== {CW'(3), 1'b1, 1'b1}) begin errors++; $display("FAIL arst_pre got cnt=%0d p=%b exp cnt=3 p=11", fifo_count, {pend1, pend2}); end
        #1;
        reset = 1'b0;
        #1;
        vectors++; if ({fifo_count, stall_req, RegWrite} !== {CW'(0), 1'b0, 1'b0})
            begin errors++; $display("FAIL arst_clear got cnt=%0d stall=%0b we=%0b exp 0 0 0", fifo_count, stall_req, RegWrite); end
        vectors++; if ({pend1, pend2} !== 2'b00) begin errors++; $display("FAIL arst_pend got %b exp 00", {pend1, pend2}); end
        model_clear();
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle_wb();
        test_drain();
        test_full();
        test_starve();
        test_set_clear();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
